pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control block that produces the freeze, bubble and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Reads the EX-side outputs of the ID/EX register (ex_memRead, ex_rd) and compares them against the source registers of the instruction currently in ID.
- Resolves load-use hazards, taken-branch flushes (branch resolved in MEM) and data-memory wait states.
- Keeps an FSM plus stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout is set (1..2^16-1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_useRs1  in  1  instruction in ID reads rs1.
- id_useRs2  in  1  instruction in ID reads rs2.
- ex_memRead  in  1  ID/EX memRead output (instruction in EX is a load).
- ex_rd  in  5  ID/EX rd output.
- mem_branchTaken  in  1  branch in MEM resolved as taken.
- mem_memReq  in  1  MEM-stage instruction accesses data memory.
- mem_memReady  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads all-zero controls (bubble).
- exmem_flush  out  1  EX/MEM loads all-zero controls.
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- state  out  2  FSM state: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_events  out  CNT_W  count of taken-branch flushes.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at posedge): state=RUN; counters=0; mem_timeout=0; wait counter=0. Control outputs are combinational and take their RUN values with inactive inputs: pc_write=1, ifid_write=1, all flush/freeze outputs 0.
- Hazard terms (combinational):
  - luse = ex_memRead & (ex_rd!=0) & ((id_useRs1 & id_rs1==ex_rd) | (id_useRs2 & id_rs2==ex_rd)).
  - mwait = mem_memReq & ~mem_memReady.
- Priority, highest first: mwait > mem_branchTaken > luse. Evaluated in every state.
  - mwait: pipe_freeze=1, pc_write=0, ifid_write=0, no flushes. Next state MEM_WAIT.
  - branch (no mwait): ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1. Next state FLUSH. flush_events increments.
  - luse (neither above): pc_write=0, ifid_write=0, idex_flush=1. Next state LOAD_STALL.
  - none: RUN outputs; next state RUN.
- In LOAD_STALL and FLUSH, luse is masked for that one cycle; ID/EX or IF/ID already holds a bubble, so exactly one bubble is inserted per load-use. mwait and branch are still honoured.
- MEM_WAIT:
  - Wait counter increments each cycle mwait=1 and clears on exit.
  - When the counter reaches MEM_TIMEOUT, mem_timeout sets; it clears only on reset. The freeze continues until mem_memReady.
- Counters:
  - stall_cycles increments every cycle pc_write=0.
  - Both counters saturate at all-ones; they do not wrap.
- Simultaneous luse and branch: branch wins and the load-use is discarded. The flushed instruction is squashed, so no stall is counted.
- Reset asserted mid-MEM_WAIT: returns to RUN next cycle, wait counter=0, mem_timeout=0.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding constants RUN, LOAD_STALL, FLUSH, MEM_WAIT;
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (width parameter, enable, synchronous active-low clear). Three instances: stall_cycles, flush_events, and the wait counter (16-bit).

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> state=0, counters=0, pc_write=1, pipe_freeze=0, mem_timeout=0.
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_useRs2=1 for one cycle, inputs held for a second cycle -> cycle 1: pc_write=0, idex_flush=1; cycle 2: state=1, no second stall; stall_cycles=1.
- x0 load: ex_memRead=1, ex_rd=0, id_rs1=0, id_useRs1=1 -> no stall, stall_cycles=0.
- Branch priority over load-use: mem_branchTaken=1 with a matching load-use -> ifid/idex/exmem_flush=1, pc_write=1, state=2 next, flush_events=1, stall_cycles=0.
- Memory wait: mem_memReq=1, mem_memReady=0 for 3 cycles then ready -> pipe_freeze=1 for exactly 3 cycles, stall_cycles=3, state returns to 0.
- Timeout: MEM_TIMEOUT=4, ready held low for 6 cycles -> mem_timeout=1 after the 4th wait cycle, still 1 after ready; cleared only by rst_n=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the bundle of stage-register controls and the x0 constant.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         WAIT_W   = 16;

  // Field order matches the bit order {pc, ifid_w, ifid_f, idex_f, exmem_f, freeze}.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // A source operand depends on the load only if it is read and names a real register.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return use_src && (rs == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory waits.
// Drives the stage-register controls and keeps stall/flush counters plus a sticky timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branchTaken,
  input  logic             mem_memReq,
  input  logic             mem_memReady,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             mem_timeout
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  ctrl_t             ctrl;
  logic              luse;
  logic              luse_masked;
  logic              mwait;
  logic              branch_ev;
  logic [WAIT_W-1:0] wait_cnt;

  assign luse  = ex_memRead && (src_hit(id_useRs1, id_rs1, ex_rd) ||
                                src_hit(id_useRs2, id_rs2, ex_rd));
  assign mwait = mem_memReq && !mem_memReady;

  // The bubble for a load-use is already in flight after a stall or flush cycle.
  assign luse_masked = (state_q == LOAD_STALL) || (state_q == FLUSH);
  assign branch_ev   = mem_branchTaken && !mwait;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = RUN;
    ctrl    = CTRL_RUN;
    if (mwait) begin
      state_d = MEM_WAIT;
      ctrl    = CTRL_FREEZE;
    end else if (mem_branchTaken) begin
      state_d = FLUSH;
      ctrl    = CTRL_FLUSH;
    end else if (luse && !luse_masked) begin
      state_d = LOAD_STALL;
      ctrl    = CTRL_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky once the wait run reaches the limit; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
    end else if (mwait && (wait_cnt >= TIMEOUT_LAST)) begin
      mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (1'b1),
    .en    (!ctrl.pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (1'b1),
    .en    (branch_ev),
    .count (flush_events)
  );

  // Counts consecutive wait cycles; any cycle without a wait leaves MEM_WAIT and clears it.
  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (mwait),
    .en    (mwait),
    .count (wait_cnt)
  );

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign pipe_freeze = ctrl.pipe_freeze;
  assign state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic compared against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TB_CNT_W = 8;
  localparam int TB_TO    = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_useRs1, id_useRs2, ex_memRead;
  logic mem_branchTaken, mem_memReq, mem_memReady;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
  logic [1:0] state;
  logic [TB_CNT_W-1:0] stall_cycles, flush_events;
  logic mem_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(TB_TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_useRs1      (id_useRs1),
    .id_useRs2      (id_useRs2),
    .ex_memRead     (ex_memRead),
    .ex_rd          (ex_rd),
    .mem_branchTaken(mem_branchTaken),
    .mem_memReq     (mem_memReq),
    .mem_memReady   (mem_memReady),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .pipe_freeze    (pipe_freeze),
    .state          (state),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .mem_timeout    (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze}
    logic [1:0] nxt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_useRs1 = 1'b0; id_useRs2 = 1'b0;
    ex_memRead = 1'b0; ex_rd = 5'd0;
    mem_branchTaken = 1'b0; mem_memReq = 1'b0; mem_memReady = 1'b0;
  endtask

  task automatic set_rand();
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_useRs1 = 1'($urandom); id_useRs2 = 1'($urandom);
    ex_memRead = 1'($urandom); ex_rd = 5'($urandom_range(0, 3));
    mem_branchTaken = ($urandom_range(0, 7) == 0);
    mem_memReq = ($urandom_range(0, 2) == 0);
    mem_memReady = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    set_idle();
  endtask

  function automatic logic [5:0] ctl_now();
    return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze};
  endfunction

  // Behavioural reference: what happened last cycle, plus plain integer counters.
  int m_last, m_stall, m_flush, m_wait;
  bit m_to;

  function automatic int model_action();
    bit mw, lu;
    mw = mem_memReq && !mem_memReady;
    lu = ex_memRead && (ex_rd != 0) &&
         ((id_useRs1 && id_rs1 == ex_rd) || (id_useRs2 && id_rs2 == ex_rd));
    // One bubble per load-use: the cycle after a stall or flush does not stall again.
    if (m_last == 1 || m_last == 2) lu = 1'b0;
    if (mw) return 3;
    if (mem_branchTaken) return 2;
    if (lu) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] model_ctl(input int act);
    case (act)
      1:       return 6'b000100;
      2:       return 6'b111110;
      3:       return 6'b000001;
      default: return 6'b110000;
    endcase
  endfunction

  task automatic model_reset();
    m_last = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
  endtask

  initial begin
    int frz;
    int act;
    rst_n = 1'b0;
    set_idle();

    vq.push_back('{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000, 2'd0});
    vq.push_back('{"luse_rs2",    5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000100, 2'd1});
    vq.push_back('{"luse_rs1",    5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000100, 2'd1});
    vq.push_back('{"rs1_unused",  5'd7, 5'd1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b110000, 2'd0});
    vq.push_back('{"x0_load",     5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000, 2'd0});
    vq.push_back('{"not_load",    5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 6'b110000, 2'd0});
    vq.push_back('{"branch",      5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b111110, 2'd2});
    vq.push_back('{"br_over_lu",  5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 6'b111110, 2'd2});
    vq.push_back('{"mwait",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000001, 2'd3});
    vq.push_back('{"mem_ready",   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 6'b110000, 2'd0});
    vq.push_back('{"mw_over_all", 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 6'b000001, 2'd3});
    vq.push_back('{"ready_noreq", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'b110000, 2'd0});

    // Reset with random inputs
    set_rand();
    rst_n = 1'b0;
    cyc();
    set_rand();
    cyc();
    rst_n = 1'b1;
    set_idle();
    #1;
    check("rst_state", state, 2'd0);
    check("rst_stall", stall_cycles, 0);
    check("rst_flush", flush_events, 0);
    check("rst_pc_write", pc_write, 1'b1);
    check("rst_freeze", pipe_freeze, 1'b0);
    check("rst_timeout", mem_timeout, 1'b0);

    // Single-cycle vector table, each applied from a fresh RUN state
    foreach (vq[i]) begin
      do_reset();
      id_rs1 = vq[i].rs1; id_rs2 = vq[i].rs2; id_useRs1 = vq[i].u1; id_useRs2 = vq[i].u2;
      ex_memRead = vq[i].mr; ex_rd = vq[i].rd; mem_branchTaken = vq[i].br;
      mem_memReq = vq[i].req; mem_memReady = vq[i].rdy;
      #1;
      check({"vec_ctl_", vq[i].name}, ctl_now(), vq[i].ctl);
      cyc();
      check({"vec_next_", vq[i].name}, state, vq[i].nxt);
    end

    // Load-use held for two cycles: exactly one bubble
    do_reset();
    ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_useRs2 = 1'b1;
    #1;
    check("lu_c1_pc_write", pc_write, 1'b0);
    check("lu_c1_idex_flush", idex_flush, 1'b1);
    cyc();
    check("lu_c2_state", state, 2'd1);
    check("lu_c2_pc_write", pc_write, 1'b1);
    check("lu_c2_idex_flush", idex_flush, 1'b0);
    cyc();
    check("lu_stall_cycles", stall_cycles, 1);
    check("lu_state_back", state, 2'd0);

    // Load into x0 never stalls
    do_reset();
    ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_useRs1 = 1'b1;
    cyc();
    check("x0_stall_cycles", stall_cycles, 0);

    // Branch coinciding with load-use
    do_reset();
    ex_memRead = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; id_useRs1 = 1'b1; mem_branchTaken = 1'b1;
    #1;
    check("brlu_ctl", ctl_now(), 6'b111110);
    cyc();
    check("brlu_state", state, 2'd2);
    check("brlu_flush_events", flush_events, 1);
    check("brlu_stall_cycles", stall_cycles, 0);

    // Three wait cycles then ready
    do_reset();
    frz = 0;
    mem_memReq = 1'b1; mem_memReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; frz += int'(pipe_freeze);
      cyc();
    end
    mem_memReady = 1'b1;
    #1; frz += int'(pipe_freeze);
    cyc();
    mem_memReq = 1'b0;
    #1; frz += int'(pipe_freeze);
    check("mw_freeze_cycles", frz, 3);
    check("mw_stall_cycles", stall_cycles, 3);
    check("mw_state", state, 2'd0);
    check("mw_no_timeout", mem_timeout, 1'b0);

    // Timeout after the fourth consecutive wait cycle, sticky past ready
    do_reset();
    mem_memReq = 1'b1; mem_memReady = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 3) check("to_after3", mem_timeout, 1'b0);
      if (k == 4) check("to_after4", mem_timeout, 1'b1);
    end
    mem_memReady = 1'b1;
    cyc();
    check("to_sticky", mem_timeout, 1'b1);
    check("to_state_run", state, 2'd0);
    // Reset in the middle of a wait
    mem_memReady = 1'b0;
    cyc();
    check("to_in_wait", state, 2'd3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    mem_memReq = 1'b0;
    #1;
    check("midrst_state", state, 2'd0);
    check("midrst_timeout", mem_timeout, 1'b0);
    // Wait counter must have restarted: three waits are below the limit
    mem_memReq = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    check("midrst_wait_cleared", mem_timeout, 1'b0);

    // Counter saturation
    do_reset();
    mem_memReq = 1'b1; mem_memReady = 1'b0;
    for (int k = 0; k < 300; k++) cyc();
    check("sat_stall", stall_cycles, CNT_MAX);
    mem_memReq = 1'b0; mem_memReady = 1'b1; mem_branchTaken = 1'b1;
    for (int k = 0; k < 300; k++) cyc();
    check("sat_flush", flush_events, CNT_MAX);
    check("sat_stall_hold", stall_cycles, CNT_MAX);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      set_rand();
      rst_n = ($urandom_range(0, 63) != 0);
      #1;
      act = model_action();
      check("rnd_ctl", ctl_now(), model_ctl(act));
      check("rnd_regs", {state, stall_cycles, flush_events, mem_timeout},
            {2'(m_last), TB_CNT_W'(m_stall), TB_CNT_W'(m_flush), m_to});
      cyc();
      if (!rst_n) begin
        model_reset();
      end else begin
        if ((act == 1 || act == 3) && m_stall < CNT_MAX) m_stall++;
        if (act == 2 && m_flush < CNT_MAX) m_flush++;
        m_wait = (act == 3) ? m_wait + 1 : 0;
        if (m_wait >= TB_TO) m_to = 1'b1;
        m_last = act;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
